adder_pipe_nbits: RTL and testbench



---
 rtl/adder_pipe_nbits.sv | 154 +++++++++++++++
 tb/tb_adder_pipe_nbits.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_nbits.sv
// -----------------------------------------------------------------------------
// adder_pipe_nbits
//   Pipelined WIDTH-bit add/subtract unit. The operands are cut into CHUNK-bit
//   slices and one slice is resolved per pipeline stage, with the inter-slice
//   carry registered between stages. Both ends use a valid/ready handshake.
//   Flow control is a global stall: every stage advances together or holds.
//
// Parameters
//   WIDTH      operand/result width (>= 1)
//   CHUNK      slice width resolved per stage (1..WIDTH)
//
// Ports
//   i_Clk      clock, rising edge
//   i_Rst      synchronous active-high reset
//   i_Valid    operand beat present
//   o_Ready    unit accepts a beat this cycle (combinational from i_Ready)
//   i_A, i_B   operands
//   i_Cin      carry-in (add mode only)
//   i_Sub      0 = A + B + Cin, 1 = A - B
//   o_Valid    result beat present
//   i_Ready    downstream accepts the result
//   o_Sum      result (modulo 2^WIDTH)
//   o_Cout     carry out of the MSB (subtract: 1 = no borrow)
//   o_Ovf      two's-complement signed overflow
//   o_Zero     o_Sum == 0
// -----------------------------------------------------------------------------
module adder_pipe_nbits #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Cin,
    input  logic             i_Sub,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_Sum,
    output logic             o_Cout,
    output logic             o_Ovf,
    output logic             o_Zero
);

    localparam int NUM_STAGES = (WIDTH + CHUNK - 1) / CHUNK;

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Subtraction is A + ~B + 1, so i_Cin is ignored in that mode.
    assign w_b_eff = i_Sub ? ~i_B : i_B;
    assign w_c0    = i_Sub | i_Cin;

    // Global stall: the whole pipe moves only when the output slot is free
    // or is being drained this cycle.
    assign w_advance = !o_Valid || i_Ready;
    assign o_Ready   = w_advance;

    // Register bank gi holds result slices 0..gi, the carry out of slice gi,
    // and (for all but the last bank) the still-unresolved upper operand bits.
    // Bank 0 resolves slice 0 directly from the accepted operands, so a beat
    // reaches the last bank NUM_STAGES-1 edges after it is accepted.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        localparam int LO   = gi * CHUNK;
        localparam int REM  = WIDTH - LO;                   // unresolved bits on entry
        localparam int SW   = (REM < CHUNK) ? REM : CHUNK;  // width of this slice
        localparam bit LAST = (gi == NUM_STAGES - 1);

        logic [REM-1:0]   w_a_in;
        logic [REM-1:0]   w_b_in;
        logic             w_c_in;
        logic             w_v_in;
        logic [SW-1:0]    w_s;
        logic             w_co;
        logic [LO+SW-1:0] w_sum_next;

        logic             r_valid;
        logic [LO+SW-1:0] r_sum;
        logic             r_c;

        if (gi == 0) begin : g_src
            assign w_a_in     = i_A;
            assign w_b_in     = w_b_eff;
            assign w_c_in     = w_c0;
            assign w_v_in     = i_Valid;
            assign w_sum_next = w_s;
        end else begin : g_src
            assign w_a_in     = g_stage[gi-1].g_fwd.r_a;
            assign w_b_in     = g_stage[gi-1].g_fwd.r_b;
            assign w_c_in     = g_stage[gi-1].r_c;
            assign w_v_in     = g_stage[gi-1].r_valid;
            assign w_sum_next = {w_s, g_stage[gi-1].r_sum};
        end

        assign {w_co, w_s} = {1'b0, w_a_in[SW-1:0]} + {1'b0, w_b_in[SW-1:0]}
                           + {{SW{1'b0}}, w_c_in};

        if (!LAST) begin : g_fwd
            logic [REM-SW-1:0] r_a;
            logic [REM-SW-1:0] r_b;

            always_ff @(posedge i_Clk) begin
                if (i_Rst) begin
                    r_valid <= 1'b0;
                    r_sum   <= '0;
                    r_c     <= 1'b0;
                    r_a     <= '0;
                    r_b     <= '0;
                end else if (w_advance) begin
                    r_valid <= w_v_in;
                    r_sum   <= w_sum_next;
                    r_c     <= w_co;
                    r_a     <= w_a_in[REM-1:SW];
                    r_b     <= w_b_in[REM-1:SW];
                end
            end
        end else begin : g_out
            logic r_ovf;
            logic r_zero;

            // Result and flags only change when a real beat lands, so they
            // keep their last value across bubbles.
            always_ff @(posedge i_Clk) begin
                if (i_Rst) begin
                    r_valid <= 1'b0;
                    r_sum   <= '0;
                    r_c     <= 1'b0;
                    r_ovf   <= 1'b0;
                    r_zero  <= 1'b0;
                end else if (w_advance) begin
                    r_valid <= w_v_in;
                    if (w_v_in) begin
                        r_sum  <= w_sum_next;
                        r_c    <= w_co;
                        // Top operand bits here are the sign bits of A and B'.
                        r_ovf  <= (w_a_in[REM-1] == w_b_in[REM-1]) &&
                                  (w_s[SW-1] != w_a_in[REM-1]);
                        r_zero <= (w_sum_next == '0);
                    end
                end
            end
        end
    end

    assign o_Valid = g_stage[NUM_STAGES-1].r_valid;
    assign o_Sum   = g_stage[NUM_STAGES-1].r_sum;
    assign o_Cout  = g_stage[NUM_STAGES-1].r_c;
    assign o_Ovf   = g_stage[NUM_STAGES-1].g_out.r_ovf;
    assign o_Zero  = g_stage[NUM_STAGES-1].g_out.r_zero;

endmodule

// File: tb/tb_adder_pipe_nbits.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe_nbits
//   Drives two instances of adder_pipe_nbits: index 0 is WIDTH=16/CHUNK=4
//   (4 stages), index 1 is WIDTH=10/CHUNK=4 (3 stages, partial top slice).
//   Expected results come from an unpipelined reference model and are queued
//   when a beat is accepted, then popped when the result is handed off.
// -----------------------------------------------------------------------------
module tb_adder_pipe_nbits;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk;
    logic        rst;
    logic [1:0]  v_in;
    logic [1:0]  rdy_in;
    logic [1:0]  cin_in;
    logic [1:0]  sub_in;
    logic [15:0] a_in [2];
    logic [15:0] b_in [2];
    logic [1:0]  rdy_out;
    logic [1:0]  vld_out;
    logic [1:0]  cout_out;
    logic [1:0]  ovf_out;
    logic [1:0]  zero_out;
    logic [15:0] sum16;
    logic [9:0]  sum10;
    logic [15:0] sum_out [2];

    res_t q0[$];
    res_t q1[$];

    int checks;
    int failures;

    assign sum_out[0] = sum16;
    assign sum_out[1] = {6'b0, sum10};

    adder_pipe_nbits #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .i_Clk   (clk),
        .i_Rst   (rst),
        .i_Valid (v_in[0]),
        .o_Ready (rdy_out[0]),
        .i_A     (a_in[0]),
        .i_B     (b_in[0]),
        .i_Cin   (cin_in[0]),
        .i_Sub   (sub_in[0]),
        .o_Valid (vld_out[0]),
        .i_Ready (rdy_in[0]),
        .o_Sum   (sum16),
        .o_Cout  (cout_out[0]),
        .o_Ovf   (ovf_out[0]),
        .o_Zero  (zero_out[0])
    );

    adder_pipe_nbits #(.WIDTH(10), .CHUNK(4)) u_dut10 (
        .i_Clk   (clk),
        .i_Rst   (rst),
        .i_Valid (v_in[1]),
        .o_Ready (rdy_out[1]),
        .i_A     (a_in[1][9:0]),
        .i_B     (b_in[1][9:0]),
        .i_Cin   (cin_in[1]),
        .i_Sub   (sub_in[1]),
        .o_Valid (vld_out[1]),
        .i_Ready (rdy_in[1]),
        .o_Sum   (sum10),
        .o_Cout  (cout_out[1]),
        .o_Ovf   (ovf_out[1]),
        .o_Zero  (zero_out[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unpipelined w-bit reference adder.
    function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        logic [31:0] mask;
        logic [31:0] ax;
        logic [31:0] bx;
        logic [31:0] full;
        logic        sa;
        logic        sb;
        logic        ss;
        mask = (32'd1 << w) - 32'd1;
        ax   = {16'b0, a} & mask;
        bx   = {16'b0, b};
        bx   = (sub ? ~bx : bx) & mask;
        full = ax + bx + {31'b0, (sub | cin)};
        r.sum  = 16'(full & mask);
        r.cout = full[w];
        sa     = ax[w-1];
        sb     = bx[w-1];
        ss     = full[w-1];
        r.ovf  = (sa == sb) && (ss != sa);
        r.zero = ((full & mask) == 32'd0);
        return r;
    endfunction

    task automatic sync();
        @(negedge clk);
    endtask

    // Apply inputs for one cycle; queue the expected result if the beat is accepted.
    task automatic drive(input int d, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic rdy, output logic acc);
        v_in[d]   = v;
        v_in[1-d] = 1'b0;
        a_in[d]   = a;
        b_in[d]   = b;
        cin_in[d] = cin;
        sub_in[d] = sub;
        rdy_in[d] = rdy;
        #1;
        acc = !rst && v && rdy_out[d];
        if (acc) begin
            if (d == 0) q0.push_back(model(16, a, b, cin, sub));
            else        q1.push_back(model(10, a, b, cin, sub));
        end
    endtask

    task automatic test_reset();
        logic acc;
        for (int i = 0; i < 2; i++) begin
            sync();
            rst = 1'b1;
            drive(0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, acc);
            v_in[1] = 1'b1;
        end
        sync();
        rst = 1'b0;
        v_in = 2'b00;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (vld_out[d] !== 1'b0 || sum_out[d] !== 16'h0000 || cout_out[d] !== 1'b0 ||
                ovf_out[d] !== 1'b0 || zero_out[d] !== 1'b0 || rdy_out[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset_state dut%0d got vld=%b sum=%h c=%b o=%b z=%b rdy=%b want vld=0 sum=0 flags=0 rdy=1",
                         d, vld_out[d], sum_out[d], cout_out[d], ovf_out[d], zero_out[d], rdy_out[d]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            sync();
            checks++;
            if (vld_out !== 2'b00) begin
                failures++;
                $display("FAIL reset_no_accept cycle %0d got vld=%b want 00", i, vld_out);
            end
        end
        $display("txn reset: both units idle after reset");
    endtask

    // One isolated beat: checks acceptance, latency and the exact result.
    task automatic test_directed(input string name, input int d, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin, input logic sub,
                                 input logic [15:0] es, input logic ec, input logic eo,
                                 input logic ez, input int lat);
        logic        acc;
        int          seen;
        logic [15:0] s;
        logic        c, o, z;
        seen = -1;
        s = '0; c = 1'b0; o = 1'b0; z = 1'b0;
        sync();
        drive(d, 1'b1, a, b, cin, sub, 1'b1, acc);
        checks++;
        if (acc !== 1'b1) begin
            failures++;
            $display("FAIL %s_accept got=%b want=1", name, acc);
        end
        for (int n = 1; n <= lat + 2 && seen < 0; n++) begin
            sync();
            if (vld_out[d] === 1'b1) begin
                seen = n;
                s = sum_out[d]; c = cout_out[d]; o = ovf_out[d]; z = zero_out[d];
            end
            drive(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
        end
        checks++;
        if (seen != lat) begin
            failures++;
            $display("FAIL %s_latency got=%0d want=%0d", name, seen, lat);
        end
        checks++;
        if (s !== es || c !== ec || o !== eo || z !== ez) begin
            failures++;
            $display("FAIL %s_result got sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                     name, s, c, o, z, es, ec, eo, ez);
        end
        if (d == 0 && q0.size() > 0) void'(q0.pop_front());
        if (d == 1 && q1.size() > 0) void'(q1.pop_front());
        $display("txn %s: a=%h b=%h cin=%b sub=%b -> sum=%h c=%b o=%b z=%b lat=%0d",
                 name, a, b, cin, sub, s, c, o, z, seen);
    endtask

    task automatic test_backpressure();
        int          n_in;
        int          n_out;
        int          stall_left;
        int          cyc;
        bit          started;
        logic        acc;
        logic        rdy;
        logic [15:0] held;
        res_t        exp;
        n_in = 0; n_out = 0; stall_left = 0; cyc = 0; started = 0; held = '0;
        while (n_out < 8 && cyc < 100) begin
            sync();
            cyc++;
            if (!started && vld_out[0] === 1'b1) begin
                started    = 1;
                stall_left = 3;
                held       = sum_out[0];
            end
            rdy = (stall_left == 0);
            drive(0, n_in < 8, 16'(n_in), 16'(n_in), 1'b0, 1'b0, rdy, acc);
            if (acc) n_in++;
            if (stall_left > 0) begin
                checks++;
                if (rdy_out[0] !== 1'b0 || vld_out[0] !== 1'b1 || sum_out[0] !== held) begin
                    failures++;
                    $display("FAIL bp_stall got rdy=%b vld=%b sum=%h want rdy=0 vld=1 sum=%h",
                             rdy_out[0], vld_out[0], sum_out[0], held);
                end
                stall_left--;
            end else if (started) begin
                checks++;
                if (vld_out[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_rate got vld=%b want 1 after %0d results", vld_out[0], n_out);
                end
            end
            if (vld_out[0] === 1'b1 && rdy) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra got sum=%h want no result", sum_out[0]);
                end else begin
                    exp = q0.pop_front();
                    if (sum_out[0] !== exp.sum || sum_out[0] !== 16'(2 * n_out)) begin
                        failures++;
                        $display("FAIL bp_result got=%h want=%h", sum_out[0], 16'(2 * n_out));
                    end
                end
                $display("txn bp: result %0d sum=%h", n_out, sum_out[0]);
                n_out++;
            end
        end
        checks++;
        if (n_out != 8 || n_in != 8 || q0.size() != 0) begin
            failures++;
            $display("FAIL bp_count got in=%0d out=%0d left=%0d want 8 8 0", n_in, n_out, q0.size());
        end
    endtask

    task automatic test_random();
        int          n_in;
        int          n_out;
        int          cyc;
        logic        acc;
        logic        v;
        logic        rdy;
        logic        prev_stall;
        logic [15:0] prev_sum;
        logic [2:0]  prev_flags;
        res_t        exp;
        n_in = 0; n_out = 0; cyc = 0; prev_stall = 1'b0; prev_sum = '0; prev_flags = '0;
        while ((n_in < 1000 || n_out < n_in) && cyc < 10000) begin
            sync();
            cyc++;
            if (prev_stall) begin
                checks++;
                if (vld_out[1] !== 1'b1 || sum_out[1] !== prev_sum ||
                    {cout_out[1], ovf_out[1], zero_out[1]} !== prev_flags) begin
                    failures++;
                    $display("FAIL rnd_hold got vld=%b sum=%h want vld=1 sum=%h",
                             vld_out[1], sum_out[1], prev_sum);
                end
            end
            v   = (n_in < 1000) && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            drive(1, v, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), rdy, acc);
            checks++;
            if (rdy_out[1] !== (!vld_out[1] || rdy)) begin
                failures++;
                $display("FAIL rnd_ready got=%b want=%b", rdy_out[1], (!vld_out[1] || rdy));
            end
            if (acc) n_in++;
            if (vld_out[1] === 1'b1 && rdy) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra got sum=%h want no result", sum_out[1]);
                end else begin
                    exp = q1.pop_front();
                    if (sum_out[1] !== exp.sum || cout_out[1] !== exp.cout ||
                        ovf_out[1] !== exp.ovf || zero_out[1] !== exp.zero) begin
                        failures++;
                        $display("FAIL rnd_result #%0d got sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                                 n_out, sum_out[1], cout_out[1], ovf_out[1], zero_out[1],
                                 exp.sum, exp.cout, exp.ovf, exp.zero);
                    end
                end
                $display("txn rnd #%0d sum=%h c=%b o=%b z=%b", n_out, sum_out[1],
                         cout_out[1], ovf_out[1], zero_out[1]);
                n_out++;
            end
            prev_stall = vld_out[1] && !rdy;
            prev_sum   = sum_out[1];
            prev_flags = {cout_out[1], ovf_out[1], zero_out[1]};
        end
        checks++;
        if (n_in != 1000 || n_out != 1000 || q1.size() != 0) begin
            failures++;
            $display("FAIL rnd_count got in=%0d out=%0d left=%0d want 1000 1000 0",
                     n_in, n_out, q1.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic acc;
        for (int i = 0; i < 3; i++) begin
            sync();
            drive(0, 1'b1, 16'(i + 1), 16'h0100, 1'b0, 1'b0, 1'b1, acc);
        end
        sync();
        rst = 1'b1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
        sync();
        rst = 1'b0;
        q0.delete();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (vld_out[0] !== 1'b0) begin
                failures++;
                $display("FAIL midrst_flush cycle %0d got vld=%b sum=%h want vld=0", i, vld_out[0], sum_out[0]);
            end
            drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
            sync();
        end
        $display("txn midrst: in-flight beats discarded");
        test_directed("after_rst", 0, 16'h00FF, 16'h0101, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0, 4);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        v_in     = 2'b00;
        rdy_in   = 2'b11;
        cin_in   = 2'b00;
        sub_in   = 2'b00;
        a_in[0]  = '0; a_in[1] = '0;
        b_in[0]  = '0; b_in[1] = '0;

        test_reset();
        test_directed("add_wrap",  0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4);
        test_directed("add_cin",   0, 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, 1'b0, 4);
        test_directed("sub_ovf",   0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 4);
        test_directed("sub_borrow",0, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4);
        test_directed("sub_cin_ign",0,16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 4);
        test_directed("w10_wrap",  1, 16'h03FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3);
        test_backpressure();
        test_random();
        test_reset_midflight();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
